wb_csr_bridge: RTL and testbench

Wishbone slave that bridges one interconnect slave port to the narrow, fixed-latency CSR bus shared by peripheral register banks. It sits directly downstream of the Wishbone interconnect and converts each single Wishbone cycle into one CSR word access. Address bits [31:28] are the interconnect's slave-select field and are ignored here.

---
 rtl/wb_csr_bridge.sv | 142 ++++++++++++++
 tb/tb_wb_csr_bridge.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_csr_bridge.sv
// Wishbone slave to fixed-latency CSR bus bridge; one Wishbone cycle maps to one CSR word access.
// Optional address range checking with wb_err_o: define WB_CSR_BRIDGE_ADDR_CHECK_EN.
module wb_csr_bridge #(
  parameter int CSR_ADDR_W = 14,
  parameter int READ_WAIT  = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [31:0]           wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic                  wb_ack_o,
  output logic [CSR_ADDR_W-1:0] csr_a,
  output logic                  csr_we,
  output logic [31:0]           csr_do,
`ifdef WB_CSR_BRIDGE_ADDR_CHECK_EN
  output logic                  wb_err_o,
`endif
  input  logic [31:0]           csr_di
);

  localparam int CNT_W = $clog2(READ_WAIT + 1);

  typedef enum logic [1:0] {IDLE, RWAIT, TURN} state_t;

  state_t                state_q, state_d;
  logic                  ack_q, ack_d;
  logic [31:0]           dat_q, dat_d;
  logic [CSR_ADDR_W-1:0] a_q, a_d;
  logic                  we_q, we_d;
  logic [31:0]           do_q, do_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  req;
  logic                  oor;
  logic                  unused_adr;

  // Slave-select bits [31:28] and byte-lane bits [1:0] never affect the access.
  assign unused_adr = ^wb_adr_i;

`ifdef WB_CSR_BRIDGE_ADDR_CHECK_EN
  // Bits 27 down to CSR_ADDR_W+2; empty when CSR_ADDR_W is 26.
  localparam logic [31:0] OOR_MASK = ((32'h1 << 28) - 32'h1) &
                                     ~((32'h1 << (CSR_ADDR_W + 2)) - 32'h1);
  logic err_q, err_d;
  assign oor      = |(wb_adr_i & OOR_MASK);
  assign wb_err_o = err_q;
`else
  assign oor = 1'b0;
`endif

  assign req = wb_cyc_i & wb_stb_i & ~ack_q;

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    we_d    = 1'b0;
    dat_d   = dat_q;
    a_d     = a_q;
    do_d    = do_q;
    cnt_d   = cnt_q;
`ifdef WB_CSR_BRIDGE_ADDR_CHECK_EN
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (oor) begin
`ifdef WB_CSR_BRIDGE_ADDR_CHECK_EN
            err_d = 1'b1;
`endif
            state_d = TURN;
          end else begin
            a_d  = wb_adr_i[CSR_ADDR_W+1:2];
            do_d = wb_dat_i;
            if (wb_we_i) begin
              we_d    = |wb_sel_i;
              ack_d   = 1'b1;
              state_d = TURN;
            end else begin
              cnt_d   = CNT_W'(READ_WAIT);
              state_d = RWAIT;
            end
          end
        end
      end
      RWAIT: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          dat_d   = csr_di;
          ack_d   = 1'b1;
          state_d = TURN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      a_q     <= '0;
      we_q    <= 1'b0;
      do_q    <= '0;
      cnt_q   <= '0;
`ifdef WB_CSR_BRIDGE_ADDR_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      a_q     <= a_d;
      we_q    <= we_d;
      do_q    <= do_d;
      cnt_q   <= cnt_d;
`ifdef WB_CSR_BRIDGE_ADDR_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign csr_a    = a_q;
  assign csr_we   = we_q;
  assign csr_do   = do_q;

endmodule

// File: tb/tb_wb_csr_bridge.sv
// Self-checking bench for wb_csr_bridge: vector table with read-data scoreboard plus corner sequences.
module tb_wb_csr_bridge;

  localparam int AW = 14;
  localparam int RW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] dat = '0;
  logic [31:0] rdat;
  logic [3:0]  sel = '0;
  logic        we  = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        ack;
  logic [AW-1:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_do;
  logic [31:0] csr_di;
`ifdef WB_CSR_BRIDGE_ADDR_CHECK_EN
  logic        err;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_csr_bridge #(.CSR_ADDR_W(AW), .READ_WAIT(RW)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .wb_adr_i(adr),
    .wb_dat_i(dat),
    .wb_dat_o(rdat),
    .wb_sel_i(sel),
    .wb_we_i (we),
    .wb_cyc_i(cyc),
    .wb_stb_i(stb),
    .wb_ack_o(ack),
    .csr_a   (csr_a),
    .csr_we  (csr_we),
    .csr_do  (csr_do),
`ifdef WB_CSR_BRIDGE_ADDR_CHECK_EN
    .wb_err_o(err),
`endif
    .csr_di  (csr_di)
  );

  // CSR register bank model
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
    end else if (csr_we) begin
      mem[csr_a] <= csr_do;
    end
  end
  assign csr_di = mem[csr_a];

  typedef struct {
    logic          we;
    logic [31:0]   adr;
    logic [31:0]   dat;
    logic [3:0]    sel;
    logic [AW-1:0] exp_a;
    logic          exp_we;
    logic [31:0]   exp_rd;
  } vec_t;

  logic [31:0] sb_q [$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int k;
    logic seen;
    logic [31:0] e;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = v.we; adr = v.adr; dat = v.dat; sel = v.sel;
    if (!v.we) sb_q.push_back(v.exp_rd);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) chk($sformatf("v%0d csr_a", idx), 32'(csr_a), 32'(v.exp_a));
      if (ack) seen = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL v%0d ack timeout: got none expected ack", idx);
    end else begin
      chk($sformatf("v%0d latency", idx), 32'(k), v.we ? 32'd1 : 32'(RW + 1));
      chk($sformatf("v%0d csr_we", idx), 32'(csr_we), 32'(v.exp_we));
`ifdef WB_CSR_BRIDGE_ADDR_CHECK_EN
      chk($sformatf("v%0d err", idx), 32'(err), 32'd0);
`endif
      if (v.we) begin
        chk($sformatf("v%0d csr_do", idx), csr_do, v.dat);
      end else if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL v%0d scoreboard: got read ack expected empty queue", idx);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("v%0d rdata", idx), rdat, e);
      end
    end
    @(posedge clk); #1;
    chk($sformatf("v%0d ack width", idx), 32'(ack), 32'd0);
    chk($sformatf("v%0d we width", idx), 32'(csr_we), 32'd0);
  endtask

  vec_t vecs [12];
  logic any_ack;
  logic any_we;
  logic [AW-1:0] a_hold;
  logic [31:0] do_hold;

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 14'h0004, 1'b1, 32'h0};
    vecs[1]  = '{1'b1, 32'h0000_0020, 32'h1234_5678, 4'h1, 14'h0008, 1'b1, 32'h0};
    vecs[2]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 14'h0008, 1'b0, 32'h1234_5678};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 14'h0004, 1'b0, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 32'h0000_0024, 32'hCAFE_F00D, 4'h0, 14'h0009, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 14'h0009, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 32'hF000_0030, 32'hA5A5_A5A5, 4'h8, 14'h000C, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_0030, 32'h0,         4'h0, 14'h000C, 1'b0, 32'hA5A5_A5A5};
    vecs[8]  = '{1'b1, 32'h0000_FFFC, 32'h1122_3344, 4'hF, 14'h3FFF, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_FFFC, 32'h0,         4'h0, 14'h3FFF, 1'b0, 32'h1122_3344};
    vecs[10] = '{1'b1, 32'h0000_0013, 32'h0000_0055, 4'h2, 14'h0004, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 14'h0004, 1'b0, 32'h0000_0055};

    repeat (3) @(posedge clk);
    #1;
    chk("reset ack", 32'(ack), 32'd0);
    chk("reset rdat", rdat, 32'd0);
    chk("reset csr_a", 32'(csr_a), 32'd0);
    chk("reset csr_we", 32'(csr_we), 32'd0);
    chk("reset csr_do", csr_do, 32'd0);
`ifdef WB_CSR_BRIDGE_ADDR_CHECK_EN
    chk("reset err", 32'(err), 32'd0);
`endif
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Master abort: cyc dropped the cycle after the read is accepted
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0000_0040; sel = 4'h0;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    any_ack = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      any_ack = any_ack | ack;
    end
    chk("abort no ack", 32'(any_ack), 32'd0);
    chk("abort rdat held", rdat, 32'h0000_0055);
    run_vec('{1'b1, 32'h0000_0004, 32'h0BAD_F00D, 4'hF, 14'h0001, 1'b1, 32'h0}, 20);

    // Reset asserted while waiting on read data
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0000_0030; sel = 4'h0;
    @(posedge clk); #1;
    chk("rwait csr_a", 32'(csr_a), 32'h000C);
    @(negedge clk);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    #1;
    chk("midrst ack", 32'(ack), 32'd0);
    chk("midrst csr_we", 32'(csr_we), 32'd0);
    chk("midrst csr_a", 32'(csr_a), 32'd0);
    chk("midrst rdat", rdat, 32'd0);
    chk("midrst csr_do", csr_do, 32'd0);
    @(negedge clk); rst = 1'b0;
    any_ack = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      any_ack = any_ack | ack;
    end
    chk("post-reset no ack", 32'(any_ack), 32'd0);

    // stb without cyc, then cyc without stb
    @(negedge clk);
    cyc = 1'b0; stb = 1'b1; we = 1'b1; adr = 32'h0000_0040; dat = 32'h1; sel = 4'hF;
    any_ack = 1'b0; any_we = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      any_ack = any_ack | ack; any_we = any_we | csr_we;
    end
    @(negedge clk);
    cyc = 1'b1; stb = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      any_ack = any_ack | ack; any_we = any_we | csr_we;
    end
    cyc = 1'b0;
    chk("no-req ack", 32'(any_ack), 32'd0);
    chk("no-req csr_we", 32'(any_we), 32'd0);
    chk("no-req csr_a", 32'(csr_a), 32'd0);

`ifdef WB_CSR_BRIDGE_ADDR_CHECK_EN
    run_vec('{1'b1, 32'h0000_0008, 32'h7777_0001, 4'hF, 14'h0002, 1'b1, 32'h0}, 30);
    a_hold  = csr_a;
    do_hold = csr_do;
    for (int w = 1; w >= 0; w--) begin
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w[0]; adr = 32'h0001_0040; dat = 32'h9999_9999; sel = 4'hF;
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0;
      chk($sformatf("oor%0d err", w), 32'(err), 32'd1);
      chk($sformatf("oor%0d ack", w), 32'(ack), 32'd0);
      chk($sformatf("oor%0d csr_we", w), 32'(csr_we), 32'd0);
      chk($sformatf("oor%0d csr_a", w), 32'(csr_a), 32'(a_hold));
      chk($sformatf("oor%0d csr_do", w), csr_do, do_hold);
      any_ack = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("oor%0d err width", w), 32'(err), 32'd0);
      repeat (RW + 1) begin
        @(posedge clk); #1;
        any_ack = any_ack | ack;
      end
      chk($sformatf("oor%0d no ack", w), 32'(any_ack), 32'd0);
    end
`endif

    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
